// File: rtl/mux_pkg.sv
// Shared types and helpers for the N:1 registered scanning multiplexer.
package mux_pkg;

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        SCAN   = 2'd1,
        IDLE   = 2'd2
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_AUTO   = 1'b1;

    // Index width that never collapses to zero bits, even for tiny counts.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_nto1_scan_if.sv
// Channel bus for mux_nto1_scan: data/select/mode/mask in, tagged sample out.
interface mux_nto1_scan_if #(
    parameter int N = 8,
    parameter int W = 1
) ();
    localparam int SW = mux_pkg::idx_width(N);

    logic [N*W-1:0] d;
    logic [SW-1:0]  sel;
    logic           mode;
    logic [N-1:0]   en_mask;
    logic [W-1:0]   y;
    logic [SW-1:0]  y_ch;
    logic           y_valid;
    logic           wrap;

    modport master (
        output d, sel, mode, en_mask,
        input  y, y_ch, y_valid, wrap
    );

    modport slave (
        input  d, sel, mode, en_mask,
        output y, y_ch, y_valid, wrap
    );

endinterface

// File: rtl/mux_next_ch.sv
// Circular priority finder: first enabled channel at or after 'start',
// wrapping past N-1. 'start' is one bit wider so that ptr+1 == N is legal.
module mux_next_ch
    import mux_pkg::*;
#(
    parameter  int N  = 8,
    localparam int SW = idx_width(N)
) (
    input  logic [N-1:0]  en_mask,
    input  logic [SW:0]   start,
    output logic [SW-1:0] next_idx,
    output logic          any_en,
    output logic          wrapped
);

    // Scan N positions from start; wrapped means the hit lies below start.
    always_comb begin
        logic found;
        int   base;
        int   k;
        found    = 1'b0;
        next_idx = '0;
        wrapped  = 1'b0;
        base     = int'(start) % N;
        k        = 0;
        for (int i = 0; i < N; i++) begin
            k = base + i;
            if (k >= N) begin
                k = k - N;
            end
            if (!found && en_mask[k[SW-1:0]]) begin
                found    = 1'b1;
                next_idx = SW'(k);
                wrapped  = (k < int'(start));
            end
        end
    end

    assign any_en = |en_mask;

endmodule

// File: rtl/mux_nto1_scan.sv
// N-channel, W-bit registered multiplexer with manual select and an
// automatic scan that dwells DWELL cycles on each enabled channel.
module mux_nto1_scan
    import mux_pkg::*;
#(
    parameter int N     = 8,
    parameter int W     = 1,
    parameter int DWELL = 4
) (
    input  logic           clk,
    input  logic           rst,
    mux_nto1_scan_if.slave bus
);

    localparam int              SW   = idx_width(N);
    localparam int              CW   = idx_width(DWELL);
    localparam logic [CW-1:0]   LAST = CW'(DWELL - 1);

    state_t         state;
    logic [SW-1:0]  ptr;
    logic [CW-1:0]  cnt;
    logic [SW:0]    search_start;
    logic [SW-1:0]  found_idx;
    logic           any_en;
    logic           found_wrapped;
    logic           sel_ok;
    logic           advance;
    logic [SW-1:0]  scan_idx;

    function automatic logic [W-1:0] chan(input logic [N*W-1:0] dv,
                                          input logic [SW-1:0]  idx);
        return dv[int'(idx)*W +: W];
    endfunction

    // Scanning searches from the slot after ptr; entering a scan searches from 0.
    always_comb begin
        search_start = '0;
        if (state == SCAN) begin
            search_start = {1'b0, ptr} + (SW+1)'(1);
        end
    end

    mux_next_ch #(.N(N)) u_next_ch (
        .en_mask  (bus.en_mask),
        .start    (search_start),
        .next_idx (found_idx),
        .any_en   (any_en),
        .wrapped  (found_wrapped)
    );

    // Manual select is only usable when it names an existing, enabled channel.
    always_comb begin
        sel_ok = 1'b0;
        if (int'(bus.sel) < N) begin
            sel_ok = bus.en_mask[bus.sel];
        end
    end

    // Pick the channel presented next: stay, advance, or the scan entry point.
    always_comb begin
        advance  = 1'b0;
        scan_idx = found_idx;
        if (state == SCAN) begin
            if (!bus.en_mask[ptr] || cnt == LAST) begin
                advance = 1'b1;
            end else begin
                scan_idx = ptr;
            end
        end else if (sel_ok) begin
            scan_idx = bus.sel;
        end
    end

    // Mode sequencer with registered, tagged outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= MANUAL;
            ptr         <= '0;
            cnt         <= '0;
            bus.y       <= '0;
            bus.y_ch    <= '0;
            bus.y_valid <= 1'b0;
            bus.wrap    <= 1'b0;
        end else if (bus.mode != MODE_AUTO) begin
            state       <= MANUAL;
            cnt         <= '0;
            bus.y       <= sel_ok ? chan(bus.d, bus.sel) : '0;
            bus.y_ch    <= bus.sel;
            bus.y_valid <= sel_ok;
            bus.wrap    <= 1'b0;
        end else if (!any_en) begin
            state       <= IDLE;
            cnt         <= '0;
            bus.y       <= '0;
            bus.y_ch    <= ptr;
            bus.y_valid <= 1'b0;
            bus.wrap    <= 1'b0;
        end else begin
            state       <= SCAN;
            ptr         <= scan_idx;
            cnt         <= (state == SCAN && !advance) ? cnt + CW'(1) : '0;
            bus.y       <= chan(bus.d, scan_idx);
            bus.y_ch    <= scan_idx;
            bus.y_valid <= 1'b1;
            bus.wrap    <= advance && found_wrapped;
        end
    end

endmodule
